// File: rtl/dram_param_pkg.sv
// Shared types and default parameters for the parameterised DRAM model.
// Refresh logic is only built when DRAM_PARAM_REFRESH_EN is defined.
package dram_param_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        REFRESH = 1'b1
    } state_e;

    localparam int DEF_DATA_W     = 72;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_REF_PERIOD = 64;
    localparam int DEF_REF_CYCLES = 4;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dram_param_rdpipe.sv
// RD_LAT-stage delay line carrying read-valid and read-data to the response port.
// Data stages only advance with a valid token, so the last stage holds the last response.
module dram_param_rdpipe
    import dram_param_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/dram_param.sv
// Single-port DRAM model with fixed read latency and optional periodic refresh.
// Define DRAM_PARAM_REFRESH_EN to build the IDLE/REFRESH controller.
module dram_param
    import dram_param_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ref_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              idleReady;
    logic              refBusy;
    logic              accept;

`ifdef DRAM_PARAM_REFRESH_EN
    localparam int REF_W  = cntWidth(REF_PERIOD);
    localparam int BUSY_W = cntWidth(REF_CYCLES);

    state_e            state_q, state_d;
    logic [REF_W-1:0]  refCnt_q, refCnt_d;
    logic [BUSY_W-1:0] busyCnt_q, busyCnt_d;
    logic              refDue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            refCnt_q  <= '0;
            busyCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            refCnt_q  <= refCnt_d;
            busyCnt_q <= busyCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        refCnt_d  = refCnt_q;
        busyCnt_d = busyCnt_q;
        case (state_q)
            IDLE: begin
                if (refDue) begin
                    state_d   = REFRESH;
                    refCnt_d  = '0;
                    busyCnt_d = '0;
                end else begin
                    refCnt_d = refCnt_q + 1'b1;
                end
            end
            REFRESH: begin
                if (busyCnt_q == BUSY_W'(REF_CYCLES - 1)) begin
                    state_d   = IDLE;
                    busyCnt_d = '0;
                end else begin
                    busyCnt_d = busyCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh wins over a waiting request: ready drops in the due cycle itself.
    always_comb begin
        refDue    = (state_q == IDLE) && (refCnt_q == REF_W'(REF_PERIOD - 1));
        refBusy   = (state_q == REFRESH);
        idleReady = (state_q == IDLE) && !refDue;
    end
`else
    assign refBusy   = 1'b0;
    assign idleReady = 1'b1;
`endif

    // Gated by rst_n so ready is low throughout reset yet high in the first cycle after it.
    assign req_ready = rst_n & idleReady;
    assign ref_busy  = refBusy;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (accept && req_write) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

    dram_param_rdpipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept & ~req_write),
        .data_i  (mem_q[req_addr]),
        .valid_o (rsp_valid),
        .data_o  (rsp_rdata)
    );

endmodule

// File: tb/tb_dram_param.sv
// Self-checking bench for dram_param: directed scenarios plus randomized traffic
// compared against a cycle-indexed reference model of the memory and refresh schedule.
module tb_dram_param;

    localparam int DATA_W     = 72;
    localparam int ADDR_W     = 2;
    localparam int RD_LAT     = 2;
    localparam int REF_PERIOD = 64;
    localparam int REF_CYCLES = 4;
    localparam int DEPTH      = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ref_busy;

    int checks   = 0;
    int failures = 0;

    dram_param #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .REF_PERIOD (REF_PERIOD),
        .REF_CYCLES (REF_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ref_busy  (ref_busy)
    );

    always #5 clk = ~clk;

    // Reference model: cycle index since reset release, scoreboard of due responses.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } pend_t;

    int                cyc;
    logic              expValid;
    logic              expReady;
    logic              expBusy;
    logic [DATA_W-1:0] expData;
    logic [DATA_W-1:0] modelMem [DEPTH];
    pend_t             pend [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            expValid = 1'b0;
            expData  = '0;
            expReady = 1'b0;
            expBusy  = 1'b0;
        end else begin
`ifdef DRAM_PARAM_REFRESH_EN
            expReady = (cyc % (REF_PERIOD + REF_CYCLES)) < (REF_PERIOD - 1);
            expBusy  = (cyc % (REF_PERIOD + REF_CYCLES)) >= REF_PERIOD;
`else
            expReady = 1'b1;
            expBusy  = 1'b0;
`endif
            expValid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                expValid = 1'b1;
                expData  = pend[0].data;
                void'(pend.pop_front());
            end
            if (req_valid && expReady) begin
                if (req_write) modelMem[req_addr] = req_wdata;
                else           pend.push_back('{cyc + RD_LAT, modelMem[req_addr]});
            end
        end
    end

    typedef struct {
        logic v;
        logic w;
        int   a;
        int   d;
        logic ev;
        int   ed;
    } op_t;

    task automatic drive(input logic v, input logic w, input int a, input int d);
        @(posedge clk);
        #1;
        req_valid = v;
        req_write = w;
        req_addr  = ADDR_W'(a);
        req_wdata = DATA_W'(d);
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %0b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0)   begin failures++; $display("[TB] FAIL reset_rdata: got %0h expected 0", rsp_rdata); end
        checks++; if (ref_busy !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", ref_busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready: got %0b expected 1", req_ready); end
    endtask

    task automatic run_table(input string name, input op_t tbl [$]);
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            @(negedge clk);
            #1;
            if (tbl[i].v) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL %s_ready step %0d: got %0b expected 1", name, i, req_ready); end
            end
            checks++; if (rsp_valid !== tbl[i].ev) begin failures++; $display("[TB] FAIL %s_valid step %0d: got %0b expected %0b", name, i, rsp_valid, tbl[i].ev); end
            checks++; if (rsp_rdata !== DATA_W'(tbl[i].ed)) begin failures++; $display("[TB] FAIL %s_rdata step %0d: got %0h expected %0h", name, i, rsp_rdata, tbl[i].ed); end
        end
        drive(1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_write_read();
        op_t tbl [$];
        tbl = '{'{1, 1, 0, 12, 0, 0},  '{1, 1, 2, 13, 0, 0},  '{1, 0, 2, 0, 0, 0},
                '{0, 0, 0, 0, 0, 0},   '{0, 0, 0, 0, 1, 13},  '{1, 1, 1, 11, 0, 13},
                '{1, 0, 1, 0, 0, 13},  '{0, 0, 0, 0, 0, 13},  '{0, 0, 0, 0, 1, 11},
                '{0, 0, 0, 0, 0, 11}};
        run_table("wr_rd", tbl);
    endtask

    task automatic test_back_to_back();
        op_t tbl [$];
        tbl = '{'{1, 1, 3, 14, 0, 11}, '{1, 0, 0, 0, 0, 11},  '{1, 0, 1, 0, 0, 11},
                '{1, 0, 2, 0, 1, 12},  '{1, 0, 3, 0, 1, 11},  '{0, 0, 0, 0, 1, 13},
                '{0, 0, 0, 0, 1, 14},  '{0, 0, 0, 0, 0, 14}};
        run_table("b2b", tbl);
    endtask

    task automatic test_random();
        logic hold = 1'b0;
        logic took;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (!hold) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_write = $urandom_range(0, 1) == 1;
                req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
                req_wdata = randData();
            end
            @(negedge clk);
            #1;
            checks++; if (req_ready !== expReady) begin failures++; $display("[TB] FAIL rnd_ready cyc %0d: got %0b expected %0b", cyc, req_ready, expReady); end
            checks++; if (ref_busy !== expBusy)   begin failures++; $display("[TB] FAIL rnd_busy cyc %0d: got %0b expected %0b", cyc, ref_busy, expBusy); end
            checks++; if (rsp_valid !== expValid) begin failures++; $display("[TB] FAIL rnd_valid cyc %0d: got %0b expected %0b", cyc, rsp_valid, expValid); end
            checks++; if (rsp_rdata !== expData)  begin failures++; $display("[TB] FAIL rnd_rdata cyc %0d: got %0h expected %0h", cyc, rsp_rdata, expData); end
            took = req_valid && req_ready;
            hold = req_valid && !took;
        end
        drive(1'b0, 1'b0, 0, 0);
    endtask

`ifdef DRAM_PARAM_REFRESH_EN
    task automatic test_refresh();
        logic took;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        for (int c = 0; c < 76; c++) begin
            @(negedge clk);
            #1;
            checks++; if (req_ready !== !(c >= 63 && c <= 67)) begin failures++; $display("[TB] FAIL ref_ready cycle %0d: got %0b expected %0b", c, req_ready, !(c >= 63 && c <= 67)); end
            checks++; if (ref_busy !== (c >= 64 && c <= 67))   begin failures++; $display("[TB] FAIL ref_busy cycle %0d: got %0b expected %0b", c, ref_busy, (c >= 64 && c <= 67)); end
            checks++; if (rsp_valid !== expValid) begin failures++; $display("[TB] FAIL ref_valid cycle %0d: got %0b expected %0b", c, rsp_valid, expValid); end
            checks++; if (rsp_rdata !== expData)  begin failures++; $display("[TB] FAIL ref_rdata cycle %0d: got %0h expected %0h", c, rsp_rdata, expData); end
            if (c == 64) begin
                checks++; if ({rsp_valid, ref_busy} !== 2'b11) begin failures++; $display("[TB] FAIL ref_rsp_during_busy: got %b expected 11", {rsp_valid, ref_busy}); end
            end
            took = req_ready;
            @(posedge clk);
            #1;
            if (took) req_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        end
        req_valid = 1'b0;
    endtask
`else
    task automatic test_no_refresh();
        for (int n = 0; n < 140; n++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_write = ($urandom_range(0, 3) == 0);
            req_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            req_wdata = randData();
            @(negedge clk);
            #1;
            checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL noref_ready cyc %0d: got %0b expected 1", cyc, req_ready); end
            checks++; if (ref_busy !== 1'b0)  begin failures++; $display("[TB] FAIL noref_busy cyc %0d: got %0b expected 0", cyc, ref_busy); end
            checks++; if (rsp_valid !== expValid) begin failures++; $display("[TB] FAIL noref_valid cyc %0d: got %0b expected %0b", cyc, rsp_valid, expValid); end
            checks++; if (rsp_rdata !== expData)  begin failures++; $display("[TB] FAIL noref_rdata cyc %0d: got %0h expected %0h", cyc, rsp_rdata, expData); end
        end
        drive(1'b0, 1'b0, 0, 0);
    endtask
`endif

    task automatic test_reset_mid_read();
        repeat (3) drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 2, 0);
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_accept: got %0b expected 1", req_ready); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ready: got %0b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %0b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0)   begin failures++; $display("[TB] FAIL midrst_rdata: got %0h expected 0", rsp_rdata); end
        checks++; if (ref_busy !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_busy: got %0b expected 0", ref_busy); end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_hold_valid: got %0b expected 0", rsp_valid); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after_valid cycle %0d: got %0b expected 0", c, rsp_valid); end
            checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_after_ready cycle %0d: got %0b expected 1", c, req_ready); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_random();
`ifdef DRAM_PARAM_REFRESH_EN
        test_refresh();
`else
        test_no_refresh();
`endif
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_param.md
DRAM_PARAM -- requirements
Module: dram_param

Interface
REQ-001 Parameter DATA_W, default 72, shall set the data word width.
REQ-002 Parameter ADDR_W, default 2, shall set the address width; depth = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 2 (legal 1..8), shall set read latency in clk cycles.
REQ-004 Parameter REF_PERIOD, default 64, shall set the number of idle-state cycles between refresh events.
REQ-005 Parameter REF_CYCLES, default 4, shall set the refresh duration in cycles.
REQ-006 clk  input  1  sole clock, rising edge; all state shall be in this one clock domain.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-014 rsp_rdata  output  DATA_W  read data; holds its last value when rsp_valid=0.
REQ-015 ref_busy  output  1  refresh in progress.

Function
REQ-016 A request shall be accepted on a rising edge where req_valid=1 and req_ready=1; there is no backpressure on the response side.
REQ-017 An accepted write shall update mem[req_addr] at the accept edge; no response is generated.
REQ-018 An accepted read shall sample mem[req_addr] at the accept edge and assert rsp_valid with that data exactly RD_LAT cycles after acceptance.
REQ-019 Back-to-back reads shall be accepted every cycle, giving one rsp_valid per read, in order, each RD_LAT cycles after acceptance.
REQ-020 A read accepted the cycle after a write to the same address shall return the new data.
REQ-021 The FSM shall have two states: IDLE (req_ready may be 1) and REFRESH (req_ready=0, ref_busy=1).
REQ-022 The refresh counter shall increment each IDLE cycle; when it equals REF_PERIOD-1, ref_due shall be 1, req_ready shall be 0 that cycle, and the FSM shall enter REFRESH on the next edge, with the counter cleared.
REQ-023 Refresh shall take priority when ref_due coincides with req_valid=1; the request shall wait and must be held by the requester.
REQ-024 REFRESH shall last exactly REF_CYCLES cycles and then return to IDLE.
REQ-025 Read responses already in the pipeline shall complete on schedule during REFRESH.
REQ-026 req_ready shall equal (state==IDLE) AND NOT ref_due, and shall not depend combinationally on req_valid.

Reset
REQ-027 While rst_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, ref_busy=0, FSM=IDLE, refresh counter=0, read pipeline valid bits cleared.
REQ-028 req_ready shall be 1 on the first cycle after rst_n deasserts.
REQ-029 Memory contents shall not be reset; a reset asserted mid-read shall discard every in-flight response.

Configuration
REQ-030 Macro DRAM_PARAM_REFRESH_EN defined: REQ-021 to REQ-025 apply.
REQ-031 Macro DRAM_PARAM_REFRESH_EN undefined: there is no refresh logic, ref_busy is tied to 0, and req_ready=1 whenever out of reset.

Structure
REQ-032 Package dram_param_pkg shall hold the FSM state typedef (IDLE, REFRESH) and the default parameter constants.
REQ-033 Sub-module dram_param_rdpipe shall implement the RD_LAT-stage valid/data delay line.

Verification
REQ-034 After reset, write addr0=12, then addr2=13, then read addr2 -> rsp_valid 2 cycles after the read, rsp_rdata=13.
REQ-035 Write addr1=11, then read addr1 on the next cycle -> rsp_rdata=11, confirming read-after-write.
REQ-036 Four back-to-back reads of addr0..3 -> four consecutive rsp_valid pulses, in address order.
REQ-037 Hold req_valid=1 from reset -> req_ready drops at cycle 63 and ref_busy is high for 4 cycles; the request is accepted at cycle 68.
REQ-038 Issue a read 1 cycle before refresh starts -> its response arrives during ref_busy=1 with correct data.
REQ-039 Assert rst_n=0 one cycle after a read accept -> no rsp_valid follows; all outputs take their REQ-027 values.
